bits_needed_ctrl: RTL and testbench

Sequential successor to the combinational bits-needed logic in the VVC CABAC arithmetic decoder. Owns the signed `m_bitsNeeded` counter and handles every shift source: regular MPS, MPS-renorm, LPS renorm and multi-bin bypass. It fetches bitstream bytes over a valid/ready handshake and tells the external `m_value` datapath when to shift and where to insert each byte. It sits between the byte-fetch FIFO and the value/range datapath, and stalls the bin decoder when a needed byte is not yet available.

---
 rtl/cabac_pkg.sv | 21 ++
 rtl/bn_shift_sel.sv | 35 +++
 rtl/bits_needed_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bits_needed_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC bits-needed controller.
package cabac_pkg;

  typedef enum logic [1:0] {
    OP_MPS    = 2'd0,
    OP_MPS_RN = 2'd1,
    OP_LPS    = 2'd2,
    OP_BYP    = 2'd3
  } op_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INIT      = 2'd1,
    ST_RUN       = 2'd2,
    ST_WAIT_BYTE = 2'd3
  } bn_state_e;

  localparam logic signed [4:0] BN_INIT = -5'sd8;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/bn_shift_sel.sv
// Mode-to-shift mux: MPS shifts 0, MPS-renorm shifts 1, LPS/bypass shift op_num.
// Oversized op_num saturates to MAX_SHIFT and raises o_err.
module bn_shift_sel
  import cabac_pkg::*;
#(
  parameter int MAX_SHIFT = 8,
  parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
  input  logic [1:0]         i_mode,
  input  logic [SHIFT_W-1:0] i_num,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_err
);

  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

  always_comb begin
    o_shift = '0;
    o_err   = 1'b0;
    case (op_mode_e'(i_mode))
      OP_MPS:    o_shift = '0;
      OP_MPS_RN: o_shift = SHIFT_W'(1);
      OP_LPS, OP_BYP: begin
        if (i_num > MAX_S) begin
          o_shift = MAX_S;
          o_err   = 1'b1;
        end else begin
          o_shift = i_num;
        end
      end
      default: o_shift = '0;
    endcase
  end

endmodule

// File: rtl/bits_needed_ctrl.sv
// CABAC bits-needed counter, byte fetch handshake and m_value shift/insert control.
// Optional BITS_NEEDED_STATS_EN adds bytes_consumed / stall_cycles counters.
//
// state        | meaning
// ST_IDLE      | no slice active, nothing accepted
// ST_INIT      | loading INIT_BYTES bytes into m_value, MSB byte first
// ST_RUN       | accepting decode ops, fetching at most one byte per op
// ST_WAIT_BYTE | op accepted but its byte missing; bin decoder stalled
module bits_needed_ctrl
  import cabac_pkg::*;
#(
  parameter int MAX_SHIFT  = 8,
  parameter int INIT_BYTES = 2,
  parameter int SHIFT_W    = $clog2(MAX_SHIFT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_i,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_mode,
  input  logic [SHIFT_W-1:0]  op_num,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                shift_valid,
  output logic [SHIFT_W-1:0]  shift_amt,
  output logic                ins_valid,
  output logic [BYTE_W-1:0]   ins_data,
  output logic [4:0]          ins_pos,
  output logic signed [3:0]   bits_needed_o,
  output logic                busy_o,
  output logic                err_o
`ifdef BITS_NEEDED_STATS_EN
  ,
  output logic [31:0]         bytes_consumed,
  output logic [31:0]         stall_cycles
`endif
);

  bn_state_e          r_state;
  logic signed [4:0]  r_bn;
  logic [1:0]         r_cnt;
  logic [2:0]         r_pos;
  logic               r_err;

  logic [SHIFT_W-1:0] w_shift;
  logic               w_sel_err;
  logic               w_op_acc;
  logic               w_byte_acc;
  logic signed [4:0]  w_t;
  logic               w_need;
  logic [4:0]         w_pos;

  bn_shift_sel #(
    .MAX_SHIFT (MAX_SHIFT),
    .SHIFT_W   (SHIFT_W)
  ) u_shift_sel (
    .i_mode  (op_mode),
    .i_num   (op_num),
    .o_shift (w_shift),
    .o_err   (w_sel_err)
  );

  // init_i blocks every handshake in its cycle so nothing is shifted or inserted.
  assign op_ready   = (r_state == ST_RUN) && !init_i;
  assign w_op_acc   = op_valid && op_ready;
  assign w_t        = r_bn + $signed(5'(w_shift));
  assign w_need     = w_op_acc && !w_t[4];

  always_comb begin
    byte_ready = 1'b0;
    if (!init_i) begin
      case (r_state)
        ST_INIT:      byte_ready = 1'b1;
        ST_WAIT_BYTE: byte_ready = 1'b1;
        ST_RUN:       byte_ready = w_need;
        default:      byte_ready = 1'b0;
      endcase
    end
  end

  assign w_byte_acc = byte_valid && byte_ready;

  always_comb begin
    w_pos = '0;
    case (r_state)
      ST_INIT:      w_pos = {r_cnt, 3'b000};
      ST_RUN:       w_pos = {2'b00, w_t[2:0]};
      ST_WAIT_BYTE: w_pos = {2'b00, r_pos};
      default:      w_pos = '0;
    endcase
  end

  assign shift_valid   = w_op_acc;
  assign shift_amt     = w_op_acc ? w_shift : '0;
  assign ins_valid     = w_byte_acc;
  assign ins_data      = w_byte_acc ? byte_data : '0;
  assign ins_pos       = w_byte_acc ? w_pos : '0;
  assign bits_needed_o = r_bn[3:0];
  assign busy_o        = (r_state == ST_INIT) || (r_state == ST_WAIT_BYTE);
  assign err_o         = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bn    <= BN_INIT;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_err   <= 1'b0;
    end else if (init_i) begin
      r_state <= ST_INIT;
      r_cnt   <= 2'(INIT_BYTES - 1);
      r_err   <= 1'b0;
    end else begin
      if (w_op_acc && w_sel_err) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_INIT: begin
          if (w_byte_acc) begin
            if (r_cnt == 2'd0) begin
              r_bn    <= BN_INIT;
              r_state <= ST_RUN;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (w_op_acc) begin
            if (w_t[4]) begin
              r_bn <= w_t;
            end else begin
              r_bn <= w_t - 5'sd8;
              if (!byte_valid) begin
                r_pos   <= w_t[2:0];
                r_state <= ST_WAIT_BYTE;
              end
            end
          end
        end
        ST_WAIT_BYTE: begin
          if (w_byte_acc) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BITS_NEEDED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_consumed <= '0;
      stall_cycles   <= '0;
    end else if (init_i) begin
      bytes_consumed <= '0;
      stall_cycles   <= '0;
    end else begin
      if (w_byte_acc && (bytes_consumed != '1)) bytes_consumed <= bytes_consumed + 32'd1;
      if ((r_state == ST_WAIT_BYTE) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bits_needed_ctrl.sv
// Self-checking bench for bits_needed_ctrl: vector table through a scoreboard plus
// hand sequences for init, stall, error and init-abort.
module tb_bits_needed_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_i;
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_mode;
  logic [3:0]        op_num;
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              shift_valid;
  logic [3:0]        shift_amt;
  logic              ins_valid;
  logic [7:0]        ins_data;
  logic [4:0]        ins_pos;
  logic signed [3:0] bits_needed_o;
  logic              busy_o;
  logic              err_o;
`ifdef BITS_NEEDED_STATS_EN
  logic [31:0]       bytes_consumed;
  logic [31:0]       stall_cycles;
`endif

  always #5 clk = ~clk;

  bits_needed_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_i        (init_i),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_mode       (op_mode),
    .op_num        (op_num),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_data     (byte_data),
    .shift_valid   (shift_valid),
    .shift_amt     (shift_amt),
    .ins_valid     (ins_valid),
    .ins_data      (ins_data),
    .ins_pos       (ins_pos),
    .bits_needed_o (bits_needed_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
`ifdef BITS_NEEDED_STATS_EN
    ,
    .bytes_consumed(bytes_consumed),
    .stall_cycles  (stall_cycles)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] num;
    logic       bv;
    logic [7:0] bd;
    logic [3:0] e_shift;
    logic       e_bready;
    logic       e_ins;
    logic [4:0] e_pos;
    logic [7:0] e_data;
    int         e_bn;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];
  vec_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_bn(input string nm, input int exp);
    n_cmp++;
    if (int'(bits_needed_o) != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, int'(bits_needed_o), exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] m, input logic [3:0] n, input logic bv, input logic [7:0] bd);
    op_valid   = 1'b1;
    op_mode    = m;
    op_num     = n;
    byte_valid = bv;
    byte_data  = bd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Running bits_needed starts at -8 after init.
    tbl[0] = '{2'd2, 4'd6, 1'b0, 8'h00, 4'd6, 1'b0, 1'b0, 5'd0, 8'h00, -2};
    tbl[1] = '{2'd3, 4'd5, 1'b1, 8'h7E, 4'd5, 1'b1, 1'b1, 5'd3, 8'h7E, -5};
    tbl[2] = '{2'd0, 4'd7, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 5'd0, 8'h00, -5};
    tbl[3] = '{2'd1, 4'd0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 5'd0, 8'h00, -4};
    tbl[4] = '{2'd2, 4'd4, 1'b1, 8'h11, 4'd4, 1'b1, 1'b1, 5'd0, 8'h11, -8};
    tbl[5] = '{2'd3, 4'd8, 1'b1, 8'hC3, 4'd8, 1'b1, 1'b1, 5'd0, 8'hC3, -8};
    tbl[6] = '{2'd2, 4'd7, 1'b0, 8'h00, 4'd7, 1'b0, 1'b0, 5'd0, 8'h00, -1};
    tbl[7] = '{2'd3, 4'd8, 1'b1, 8'h5A, 4'd8, 1'b1, 1'b1, 5'd7, 8'h5A, -1};
    tbl[8] = '{2'd0, 4'd15, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 5'd0, 8'h00, -1};
    tbl[9] = '{2'd3, 4'd3, 1'b1, 8'h99, 4'd3, 1'b1, 1'b1, 5'd2, 8'h99, -6};

    rst_n = 1'b0; init_i = 1'b0; op_valid = 1'b1; op_mode = 2'd2; op_num = 4'd3;
    byte_valid = 1'b1; byte_data = 8'hFF;
    #12;
    chk_bn("rst_bn", -8);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_shift_valid", shift_valid, 0);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins_pos", ins_pos, 0);
    chk("rst_ins_data", ins_data, 0);
    chk("rst_shift_amt", shift_amt, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);

    @(negedge clk); rst_n = 1'b1; #2;
    chk("idle_op_ready", op_ready, 0);
    chk("idle_byte_ready", byte_ready, 0);

    @(negedge clk); op_valid = 1'b0; byte_valid = 1'b0; init_i = 1'b1; #2;
    chk("init_cyc_byte_ready", byte_ready, 0);
    @(negedge clk); init_i = 1'b0; byte_valid = 1'b1; byte_data = 8'hA5; #2;
    chk("init_busy", busy_o, 1);
    chk("init_b0_ins_valid", ins_valid, 1);
    chk("init_b0_pos", ins_pos, 8);
    chk("init_b0_data", ins_data, 8'hA5);
    @(negedge clk); byte_data = 8'h3C; #2;
    chk("init_b1_ins_valid", ins_valid, 1);
    chk("init_b1_pos", ins_pos, 0);
    chk("init_b1_data", ins_data, 8'h3C);
    @(negedge clk); byte_valid = 1'b0; #2;
    chk_bn("init_done_bn", -8);
    chk("init_done_busy", busy_o, 0);
    chk("init_done_op_ready", op_ready, 1);
    chk("run_no_need_byte_ready", byte_ready, 0);

    for (int i = 0; i < 10; i++) begin
      drive_op(tbl[i].mode, tbl[i].num, tbl[i].bv, tbl[i].bd);
      sb.push_back(tbl[i]);
      #2;
      cur = sb.pop_front();
      chk($sformatf("v%0d_op_ready", i), op_ready, 1);
      chk($sformatf("v%0d_shift_valid", i), shift_valid, 1);
      chk($sformatf("v%0d_shift_amt", i), shift_amt, cur.e_shift);
      chk($sformatf("v%0d_byte_ready", i), byte_ready, cur.e_bready);
      chk($sformatf("v%0d_ins_valid", i), ins_valid, cur.e_ins);
      chk($sformatf("v%0d_ins_pos", i), ins_pos, cur.e_pos);
      chk($sformatf("v%0d_ins_data", i), ins_data, cur.e_data);
      @(negedge clk); op_valid = 1'b0; byte_valid = 1'b0; #1;
      chk_bn($sformatf("v%0d_bn", i), cur.e_bn);
      chk($sformatf("v%0d_busy", i), busy_o, 0);
    end

    // Stall: bits_needed -1, MPS-renorm with no byte for three cycles.
    drive_op(2'd2, 4'd5, 1'b0, 8'h00); #2;
    chk("pre_stall_shift", shift_amt, 5);
    @(negedge clk); op_valid = 1'b0; #1;
    chk_bn("pre_stall_bn", -1);
    drive_op(2'd1, 4'd0, 1'b0, 8'h00); #2;
    chk("stall_acc_shift_valid", shift_valid, 1);
    chk("stall_acc_shift_amt", shift_amt, 1);
    chk("stall_acc_byte_ready", byte_ready, 1);
    chk("stall_acc_ins_valid", ins_valid, 0);
    @(negedge clk); #1;
    chk_bn("stall_bn", -8);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall%0d_op_ready", k), op_ready, 0);
      chk($sformatf("stall%0d_shift_valid", k), shift_valid, 0);
      chk($sformatf("stall%0d_busy", k), busy_o, 1);
      chk($sformatf("stall%0d_byte_ready", k), byte_ready, 1);
      @(negedge clk); #1;
    end
    byte_valid = 1'b1; byte_data = 8'h42; #1;
    chk("stall_arr_op_ready", op_ready, 0);
    chk("stall_arr_ins_valid", ins_valid, 1);
    chk("stall_arr_pos", ins_pos, 0);
    chk("stall_arr_data", ins_data, 8'h42);
    @(negedge clk); byte_valid = 1'b0; op_valid = 1'b0; #1;
    chk("stall_end_op_ready", op_ready, 1);
    chk("stall_end_busy", busy_o, 0);
    chk_bn("stall_end_bn", -8);
`ifdef BITS_NEEDED_STATS_EN
    chk("stats_stall_cycles", stall_cycles, 3);
    chk("stats_bytes", bytes_consumed, 8);
`endif

    // Oversized bypass count saturates and latches the error.
    drive_op(2'd3, 4'd9, 1'b1, 8'h01); #2;
    chk("err_shift_amt", shift_amt, 8);
    chk("err_ins_valid", ins_valid, 1);
    chk("err_pos", ins_pos, 0);
    chk("err_not_yet", err_o, 0);
    @(negedge clk); op_valid = 1'b0; byte_valid = 1'b0; #1;
    chk("err_set", err_o, 1);
    chk_bn("err_bn", -8);
    drive_op(2'd0, 4'd0, 1'b0, 8'h00);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("err_sticky", err_o, 1);

    // init_i while waiting for a byte drops the pending insert.
    drive_op(2'd2, 4'd8, 1'b0, 8'h00); #2;
    chk("abort_acc_byte_ready", byte_ready, 1);
    chk("abort_acc_ins_valid", ins_valid, 0);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("abort_wait_busy", busy_o, 1);
    init_i = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE; #1;
    chk("abort_ins_valid", ins_valid, 0);
    chk("abort_byte_ready", byte_ready, 0);
    chk("abort_shift_valid", shift_valid, 0);
    @(negedge clk); init_i = 1'b0; byte_data = 8'h12; #1;
    chk("abort_err_clr", err_o, 0);
    chk("abort_init_busy", busy_o, 1);
    chk("abort_b0_pos", ins_pos, 8);
    chk("abort_b0_data", ins_data, 8'h12);
    @(negedge clk); byte_data = 8'h34; #1;
    chk("abort_b1_pos", ins_pos, 0);
    chk("abort_b1_data", ins_data, 8'h34);
    @(negedge clk); byte_valid = 1'b0; #1;
    chk_bn("abort_done_bn", -8);
    chk("abort_done_busy", busy_o, 0);
    chk("abort_done_op_ready", op_ready, 1);
`ifdef BITS_NEEDED_STATS_EN
    chk("abort_stats_bytes", bytes_consumed, 2);
    chk("abort_stats_stall", stall_cycles, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
